// File: rtl/seq_alu.sv
// Registered ALU for the multi-cycle MIPS datapath. Single-cycle logic ops plus
// iterative unsigned shift-add multiply and restoring divide, with a start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       ALUcontrol,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             divzero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     dvsr, rem, quo;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt, alu_res;
  logic [WIDTH:0]       rem_sh, rem_try;
  logic                 q_bit, last;

  always_comb begin
    alu_res = '0;
    case (ALUcontrol)
      OP_AND:  alu_res = srca & srcb;
      OP_OR:   alu_res = srca | srcb;
      OP_ADD:  alu_res = srca + srcb;
      OP_SUB:  alu_res = srca - srcb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_NOR:  alu_res = ~(srca | srcb);
      OP_XOR:  alu_res = srca ^ srcb;
      default: alu_res = '0;
    endcase
  end

  // One iteration of each long op; the divide trial subtract borrows into bit WIDTH
  // exactly when the shifted remainder is below the divisor.
  always_comb begin
    acc_nxt = mplier[0] ? acc + mcand : acc;
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_try = rem_sh - {1'b0, dvsr};
    q_bit   = ~rem_try[WIDTH];
    rem_nxt = q_bit ? rem_try[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], q_bit};
    last    = (cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
      hi      <= '0;
      zero    <= 1'b0;
      divzero <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      dvsr    <= '0;
      rem     <= '0;
      quo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          case (ALUcontrol)
            OP_MULTU: begin
              mcand  <= {{WIDTH{1'b0}}, srca};
              mplier <= srcb;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end
            OP_DIVU: begin
              if (srcb == '0) begin
                out     <= '1;
                hi      <= srca;
                zero    <= 1'b0;
                divzero <= 1'b1;
                done    <= 1'b1;
              end else begin
                dvsr  <= srcb;
                quo   <= srca;
                rem   <= '0;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= DIV;
              end
            end
            default: begin
              out  <= alu_res;
              hi   <= '0;
              zero <= (alu_res == '0);
              done <= 1'b1;
            end
          endcase
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            out   <= acc_nxt[WIDTH-1:0];
            hi    <= acc_nxt[2*WIDTH-1:WIDTH];
            zero  <= (acc_nxt[WIDTH-1:0] == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            out     <= quo_nxt;
            hi      <= rem_nxt;
            zero    <= (quo_nxt == '0);
            divzero <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus random checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  srca, srcb;
  logic [3:0]    ALUcontrol;
  logic          busy, done, zero, divzero;
  logic [W-1:0]  out, hi;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] e_out, e_hi;
  logic         e_zero, e_dz;
  int           e_lat;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
    .ALUcontrol(ALUcontrol), .busy(busy), .done(done), .out(out), .hi(hi),
    .zero(zero), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result of an op straight from its arithmetic definition.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned p;
    e_hi  = '0;
    e_lat = 0;
    case (op)
      4'b0000: e_out = a & b;
      4'b0001: e_out = a | b;
      4'b0010: e_out = a + b;
      4'b0110: e_out = a - b;
      4'b0111: e_out = (int'(a) < int'(b)) ? 1 : 0;
      4'b0100: e_out = ~(a | b);
      4'b0011: e_out = a ^ b;
      4'b1000: begin
        p     = longint'(a) * longint'(b);
        e_out = p[31:0];
        e_hi  = p[63:32];
        e_lat = W;
      end
      4'b1001: begin
        if (b == 0) begin
          e_out = '1; e_hi = a; e_dz = 1'b1;
        end else begin
          e_out = a / b; e_hi = a % b; e_dz = 1'b0; e_lat = W;
        end
      end
      default: e_out = '0;
    endcase
    e_zero = (e_out == 0);
  endtask

  // Drive a request for one edge; returns at the negedge just after acceptance.
  task automatic accept(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    chk("idle_done_low", 64'(done), 64'(0));
    chk("hold_out", 64'(out), 64'(e_out));
    start = 1'b1; ALUcontrol = op; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = $urandom; srcb = $urandom; ALUcontrol = 4'($urandom);
    model(op, a, b);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n;
    accept(op, a, b);
    n = 0;
    while (!done && n < W + 4) begin
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(e_lat));
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    chk({tag, "_out"}, 64'(out), 64'(e_out));
    chk({tag, "_hi"}, 64'(hi), 64'(e_hi));
    chk({tag, "_zero"}, 64'(zero), 64'(e_zero));
    chk({tag, "_divzero"}, 64'(divzero), 64'(e_dz));
  endtask

  initial begin
    int ndone, first;
    logic [3:0] op;
    logic [W-1:0] a, b;

    reset = 1'b1; start = 1'b0; srca = '0; srcb = '0; ALUcontrol = '0;
    e_out = '0; e_hi = '0; e_zero = 1'b0; e_dz = 1'b0; e_lat = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out", 64'(out), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    chk("rst_divzero", 64'(divzero), 64'(0));

    // Back-to-back SUBs: done every cycle, never busy
    @(negedge clk);
    start = 1'b1; ALUcontrol = 4'b0110; srca = 15; srcb = 15;
    @(negedge clk);
    chk("sub0_done", 64'(done), 64'(1));
    chk("sub0_out", 64'(out), 64'(0));
    chk("sub0_zero", 64'(zero), 64'(1));
    chk("sub0_busy", 64'(busy), 64'(0));
    srcb = 16;
    @(negedge clk);
    chk("sub1_done", 64'(done), 64'(1));
    chk("sub1_out", 64'(out), 64'(32'hFFFF_FFFF));
    chk("sub1_zero", 64'(zero), 64'(0));
    chk("sub1_busy", 64'(busy), 64'(0));
    start = 1'b0;
    model(4'b0110, 15, 16);

    do_op("slt", 4'b0111, 32'hFFFF_FFFF, 1);
    chk("slt_val", 64'(out), 64'(1));
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 1);
    chk("add_wrap_zero", 64'(zero), 64'(1));
    do_op("nor", 4'b0100, 0, 0);
    chk("nor_val", 64'(out), 64'(32'hFFFF_FFFF));
    do_op("mul", 4'b1000, 32'hFFFF_FFFF, 2);
    chk("mul_hi_val", 64'(hi), 64'(1));
    chk("mul_lo_val", 64'(out), 64'(32'hFFFF_FFFE));
    do_op("div", 4'b1001, 100, 7);
    chk("div_q", 64'(out), 64'(14));
    chk("div_r", 64'(hi), 64'(2));
    do_op("div0", 4'b1001, 5, 0);
    chk("div0_flag", 64'(divzero), 64'(1));

    // start during MULTU must be ignored; exactly one done
    accept(4'b1000, 32'hFFFF_FFFF, 2);
    ndone = 0; first = -1;
    for (int n = 0; n < W + 6; n++) begin
      if (n == 10) begin start = 1'b1; ALUcontrol = 4'b0010; srca = 3; srcb = 4; end
      if (n == 11) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = n;
        chk("ign_busy_at_done", 64'(busy), 64'(0));
      end else if (n < W) begin
        chk("ign_busy", 64'(busy), 64'(1));
      end
      @(negedge clk);
    end
    chk("ign_ndone", 64'(ndone), 64'(1));
    chk("ign_lat", 64'(first), 64'(W));
    chk("ign_out", 64'(out), 64'(e_out));
    chk("ign_hi", 64'(hi), 64'(e_hi));

    // Reset mid-DIVU aborts without a done pulse
    accept(4'b1001, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_out", 64'(out), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_divzero", 64'(divzero), 64'(0));
    e_out = '0; e_hi = '0; e_zero = 1'b0; e_dz = 1'b0;
    for (int n = 0; n < W + 2; n++) begin
      @(negedge clk);
      if (done) chk("abort_late_done", 64'(done), 64'(0));
    end
    chk("abort_idle", 64'(busy), 64'(0));
    do_op("add11", 4'b0010, 1, 1);
    chk("add11_val", 64'(out), 64'(2));

    // Random mix
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) != 0) ? 4'b1000 : 4'b1001;
      a = $urandom;
      b = ($urandom_range(0, 1) != 0) ? $urandom : W'($urandom_range(0, 50));
      if (op == 4'b1001 && $urandom_range(0, 3) == 0) b = '0;
      do_op("rand", op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU for the multi-cycle MIPS datapath. It extends the combinational ALU op set with iterative unsigned multiply and divide, and produces a HI result for both. Single-cycle ops complete in one clock. MULTU and DIVU take WIDTH clocks. A start/busy/done handshake lets the multi-cycle control FSM stall on long ops.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 4).

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; srca/srcb/ALUcontrol sampled on the edge where start=1 and busy=0
srca  input  WIDTH  operand A
srcb  input  WIDTH  operand B
ALUcontrol  input  4  operation select
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: out/hi/zero/divzero valid and updated
out  output  WIDTH  result (low product / quotient for MULTU/DIVU)
hi  output  WIDTH  high product / remainder; 0 for single-cycle ops
zero  output  1  registered (out == 0)
divzero  output  1  last DIVU had srcb == 0

Behaviour:
- Reset (synchronous, priority over everything): FSM goes to IDLE; busy, done, out, hi, zero, divzero all 0.
- A reset during MUL or DIV aborts the op. No done pulse is issued.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^WIDTH); 0110 SUB (A-B, mod 2^WIDTH).
  - 0111 SLT: signed A<B gives 1, else 0, zero-extended.
  - 0100 NOR; 0011 XOR.
  - 1000 MULTU; 1001 DIVU.
  - Any other code: out=0, single-cycle.
- FSM states: IDLE, MUL, DIV.
- IDLE + accepted single-cycle op (edge k):
  - out, zero updated at edge k; hi=0; divzero unchanged.
  - done=1 for the cycle after edge k; busy stays 0.
- IDLE + MULTU at edge k: load multiplicand/multiplier, clear the 2*WIDTH accumulator, set busy=1, go to MUL.
  - Shift-add, one multiplier bit per edge, edges k+1..k+WIDTH.
  - At edge k+WIDTH: {hi,out} = A*B (unsigned, 2*WIDTH bits), busy=0, done=1, return to IDLE.
- IDLE + DIVU with srcb != 0 at edge k: busy=1, go to DIV.
  - Restoring division, one quotient bit per edge, edges k+1..k+WIDTH.
  - At edge k+WIDTH: out=floor(A/B), hi=A mod B, divzero=0, busy=0, done=1.
- DIVU with srcb == 0: single-cycle at edge k.
  - out = all ones, hi = srca, divzero=1, zero=0, done=1, busy stays 0.
- zero always tracks the out value written at the same edge, for every op.
- out/hi/zero/divzero hold their values between done pulses.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - Operands may change after acceptance without affecting the op.
- Back-to-back:
  - start may be asserted in the same cycle done=1 (busy=0) and is accepted.
  - Consecutive single-cycle ops therefore give done=1 every cycle.
- done is never asserted while busy=1. busy and done are never both 1 in the same cycle.
- All internal shift registers are sized from WIDTH; no hard-coded 32.

Test Plan:
- WIDTH=32, SUB 15-15, then SUB 15-16 on the next cycle:
  - out=0, zero=1, done pulse on the first;
  - out=0xFFFFFFFF, zero=0 on the second;
  - busy stays 0 throughout.
- SLT A=0xFFFFFFFF, B=1 -> out=1. ADD 0xFFFFFFFF+1 -> out=0, zero=1. NOR 0,0 -> 0xFFFFFFFF.
- MULTU 0xFFFFFFFF*2:
  - busy=1 for 32 cycles;
  - done exactly 32 edges after acceptance;
  - hi=0x00000001, out=0xFFFFFFFE.
- DIVU 100/7 -> after 32 cycles out=14, hi=2, divzero=0. Then DIVU 5/0 -> done next cycle, out=0xFFFFFFFF, hi=5, divzero=1.
- During MULTU, pulse start with ADD 3+4 at cycle 10 -> ignored; product result is unchanged and only one done pulse occurs.
- Assert reset at cycle 5 of DIVU:
  - next cycle busy=0, out=0, hi=0, no done pulse;
  - a following ADD 1+1 gives out=2 normally.
